// File: rtl/sp_ram_arb.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Read data returns one cycle after acceptance and is held per requester.
module sp_ram_arb #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   logic              last_grant;
   logic              rd_pend;
   logic              rd_owner;
   logic [DATA_W-1:0] held0;
   logic [DATA_W-1:0] held1;
   logic              gnt0;
   logic              gnt1;
   logic              rd_acc;

   // Grant: contention goes to the requester that did not win last
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         if (r0_valid && r1_valid) begin
            gnt0 = last_grant;
            gnt1 = ~last_grant;
         end else begin
            gnt0 = r0_valid;
            gnt1 = r1_valid;
         end
      end
   end

   assign r0_ready = gnt0;
   assign r1_ready = gnt1;
   assign rd_acc   = (gnt0 & ~r0_we) | (gnt1 & ~r1_we);

   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      if (gnt0) begin
         ram_en   = 1'b1;
         ram_we   = r0_we;
         ram_addr = r0_addr;
         ram_din  = r0_wdata;
      end else if (gnt1) begin
         ram_en   = 1'b1;
         ram_we   = r1_we;
         ram_addr = r1_addr;
         ram_din  = r1_wdata;
      end
   end

   // Response stage: RAM output is valid the cycle after an accepted read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         rd_pend    <= 1'b0;
         rd_owner   <= 1'b0;
         held0      <= '0;
         held1      <= '0;
      end else begin
         if (gnt0 || gnt1) last_grant <= gnt1;
         rd_pend <= rd_acc;
         if (rd_acc) rd_owner <= gnt1;
         if (rd_pend) begin
            if (rd_owner) held1 <= ram_dout;
            else          held0 <= ram_dout;
         end
      end
   end

   assign r0_rvalid = rd_pend & ~rd_owner;
   assign r1_rvalid = rd_pend & rd_owner;
   assign r0_rdata  = r0_rvalid ? ram_dout : held0;
   assign r1_rdata  = r1_rvalid ? ram_dout : held1;

endmodule

// File: tb/tb_sp_ram_arb.sv
// Bench for sp_ram_arb: behavioural RAM plus a transaction-level arbiter model.
module tb_sp_ram_arb;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 14;
   localparam int VW = 4 + ADDR_W + DATA_W + 2 + 2 * DATA_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              r0_valid, r0_we, r1_valid, r1_we;
   logic [ADDR_W-1:0] r0_addr, r1_addr;
   logic [DATA_W-1:0] r0_wdata, r1_wdata;
   logic              r0_ready, r1_ready, r0_rvalid, r1_rvalid;
   logic [DATA_W-1:0] r0_rdata, r1_rdata;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout = '0;

   logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];

   int n_checks = 0;
   int n_fail = 0;

   // reference model state
   int                m_last;
   bit                m_pend;
   int                m_owner;
   logic [DATA_W-1:0] m_pdata;
   logic [DATA_W-1:0] m_held [2];
   logic [DATA_W-1:0] exp_mem [0:(1<<ADDR_W)-1];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_din;
         else        ram_dout <= ram_mem[ram_addr];
      end
   end

   sp_ram_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we),
      .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we),
      .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   function automatic int exp_gnt();
      if (!rst_n) return -1;
      if (r0_valid && r1_valid) return (m_last == 1) ? 0 : 1;
      if (r0_valid) return 0;
      if (r1_valid) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      m_last = 1;
      m_pend = 0;
      m_owner = 0;
      m_pdata = '0;
      m_held[0] = '0;
      m_held[1] = '0;
   endtask

   task automatic set_in(input logic v0, input logic we0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic v1, input logic we1,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
      r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
      r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
   endtask

   task automatic idle();
      set_in(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   // commit the transaction the model predicts for this cycle, then move past the edge
   task automatic advance();
      int g;
      logic we;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      g = exp_gnt();
      if (m_pend) m_held[m_owner] = m_pdata;
      m_pend = 0;
      if (g >= 0) begin
         we = (g == 0) ? r0_we : r1_we;
         a  = (g == 0) ? r0_addr : r1_addr;
         d  = (g == 0) ? r0_wdata : r1_wdata;
         m_last = g;
         if (we) exp_mem[a] = d;
         else begin
            m_pend = 1;
            m_owner = g;
            m_pdata = exp_mem[a];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_in(1, 0, 14'd5, 8'h00, 1, 0, 14'd6, 8'h00);
      #3;
      n_checks++;
      if ({r0_ready, r1_ready, ram_en, ram_we} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 0000", {r0_ready, r1_ready, ram_en, ram_we});
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_resp: got rv=%b%b rd0=%h rd1=%h want 0", r0_rvalid, r1_rvalid,
                  r0_rdata, r1_rdata);
      end
      idle();
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read();
      set_in(1, 1, 14'd3, 8'hA5, 0, 0, '0, '0);
      @(negedge clk);
      n_checks++;
      if ({r0_ready, r1_ready, ram_en, ram_we, ram_addr, ram_din} !== {4'b1011, 14'd3, 8'hA5}) begin
         n_fail++;
         $display("FAIL wr_drive: got rdy=%b%b en=%b we=%b a=%h d=%h", r0_ready, r1_ready, ram_en,
                  ram_we, ram_addr, ram_din);
      end
      advance();
      set_in(1, 0, 14'd3, 8'h00, 0, 0, '0, '0);
      @(negedge clk);
      n_checks++;
      if ({r0_ready, ram_en, ram_we, r0_rvalid} !== 4'b1100) begin
         n_fail++;
         $display("FAIL rd_drive: got rdy=%b en=%b we=%b rv=%b want 1100", r0_ready, ram_en,
                  ram_we, r0_rvalid);
      end
      advance();
      idle();
      @(negedge clk);
      n_checks++;
      if (r0_rvalid !== 1'b1 || r0_rdata !== 8'hA5) begin
         n_fail++;
         $display("FAIL rd_resp: got rv=%b rd=%h want 1 a5", r0_rvalid, r0_rdata);
      end
      advance();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (r0_rvalid !== 1'b0 || r0_rdata !== 8'hA5 || ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_hold%0d: got rv=%b rd=%h en=%b want 0 a5 0", i, r0_rvalid,
                     r0_rdata, ram_en);
         end
         advance();
      end
   endtask

   task automatic test_contention();
      set_in(1, 1, 14'd1, 8'h11, 0, 0, '0, '0);
      advance();
      set_in(0, 0, '0, '0, 1, 1, 14'd2, 8'h22);
      advance();
      for (int i = 0; i < 4; i++) begin
         logic [1:0] e_rdy, e_rv;
         set_in(1, 0, 14'd1, 8'h00, 1, 0, 14'd2, 8'h00);
         e_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
         e_rv  = (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b10 : 2'b01);
         @(negedge clk);
         n_checks++;
         if ({r0_ready, r1_ready} !== e_rdy || {r0_rvalid, r1_rvalid} !== e_rv) begin
            n_fail++;
            $display("FAIL contend%0d: got rdy=%b%b rv=%b%b want rdy=%b rv=%b", i, r0_ready,
                     r1_ready, r0_rvalid, r1_rvalid, e_rdy, e_rv);
         end
         advance();
      end
      idle();
      @(negedge clk);
      n_checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b01 || r0_rdata !== 8'h11 || r1_rdata !== 8'h22) begin
         n_fail++;
         $display("FAIL contend_data: got rv=%b%b rd0=%h rd1=%h want 01 11 22", r0_rvalid,
                  r1_rvalid, r0_rdata, r1_rdata);
      end
      advance();
   endtask

   task automatic test_single();
      for (int i = 0; i < 4; i++) begin
         logic [DATA_W-1:0] d;
         d = DATA_W'(i + 1);
         set_in(0, 0, '0, '0, 1, (i < 3), 14'd7, d);
         @(negedge clk);
         n_checks++;
         if ({r0_ready, r1_ready, r0_rvalid} !== 3'b010) begin
            n_fail++;
            $display("FAIL single%0d: got rdy=%b%b rv0=%b want 010", i, r0_ready, r1_ready,
                     r0_rvalid);
         end
         advance();
      end
      idle();
      @(negedge clk);
      n_checks++;
      if (r1_rvalid !== 1'b1 || r1_rdata !== 8'h03 || r0_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rd: got rv1=%b rd1=%h rv0=%b want 1 03 0", r1_rvalid, r1_rdata,
                  r0_rvalid);
      end
      advance();
   endtask

   task automatic test_war();
      set_in(1, 1, 14'd4, 8'h44, 0, 0, '0, '0);
      advance();
      set_in(1, 0, 14'd4, 8'h00, 0, 0, '0, '0);
      advance();
      set_in(0, 0, '0, '0, 1, 1, 14'd4, 8'h99);
      @(negedge clk);
      n_checks++;
      if ({r1_ready, r0_rvalid, r1_rvalid} !== 3'b110 || r0_rdata !== 8'h44) begin
         n_fail++;
         $display("FAIL war_resp: got rdy1=%b rv=%b%b rd0=%h want 1 10 44", r1_ready,
                  r0_rvalid, r1_rvalid, r0_rdata);
      end
      advance();
      idle();
      @(negedge clk);
      n_checks++;
      if (r0_rvalid !== 1'b0 || r0_rdata !== 8'h44) begin
         n_fail++;
         $display("FAIL war_hold: got rv0=%b rd0=%h want 0 44", r0_rvalid, r0_rdata);
      end
      advance();
      set_in(1, 0, 14'd4, 8'h00, 0, 0, '0, '0);
      advance();
      idle();
      @(negedge clk);
      n_checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b10 || r0_rdata !== 8'h99) begin
         n_fail++;
         $display("FAIL raw_resp: got rv=%b%b rd0=%h want 10 99", r0_rvalid, r1_rvalid, r0_rdata);
      end
      advance();
   endtask

   task automatic test_reset_mid();
      set_in(1, 0, 14'd4, 8'h00, 0, 0, '0, '0);
      advance();
      idle();
      #1;
      n_checks++;
      if (r0_rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pend: got rv0=%b want 1", r0_rvalid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata} !== '0) begin
         n_fail++;
         $display("FAIL mid_clear: got rv=%b%b rd0=%h rd1=%h want 0", r0_rvalid, r1_rvalid,
                  r0_rdata, r1_rdata);
      end
      model_reset();
      set_in(1, 0, 14'd1, 8'h00, 1, 0, 14'd2, 8'h00);
      @(negedge clk);
      n_checks++;
      if ({r0_ready, r1_ready, ram_en} !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_inreset: got rdy=%b%b en=%b want 000", r0_ready, r1_ready, ram_en);
      end
      #1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL mid_first: got rdy=%b%b want 10", r0_ready, r1_ready);
      end
      advance();
      @(negedge clk);
      n_checks++;
      if ({r0_ready, r1_ready, r0_rvalid} !== 3'b011 || r0_rdata !== 8'h11) begin
         n_fail++;
         $display("FAIL mid_next: got rdy=%b%b rv0=%b rd0=%h want 011 11", r0_ready, r1_ready,
                  r0_rvalid, r0_rdata);
      end
      advance();
      idle();
      advance();
   endtask

   task automatic test_idle();
      for (int k = 0; k < 2; k++) begin
         logic [1:0] e_rdy;
         if (k == 0) set_in(0, 0, '0, '0, 1, 1, 14'd9, 8'h05);
         else        set_in(1, 1, 14'd9, 8'h06, 0, 0, '0, '0);
         e_rdy = (k == 0) ? 2'b10 : 2'b01;
         advance();
         idle();
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({r0_ready, r1_ready, ram_en, ram_we, ram_addr, ram_din} !== '0) begin
               n_fail++;
               $display("FAIL idle%0d_%0d: got rdy=%b%b en=%b we=%b a=%h d=%h", k, i, r0_ready,
                        r1_ready, ram_en, ram_we, ram_addr, ram_din);
            end
            advance();
         end
         set_in(1, 0, 14'd9, 8'h00, 1, 0, 14'd9, 8'h00);
         @(negedge clk);
         n_checks++;
         if ({r0_ready, r1_ready} !== e_rdy) begin
            n_fail++;
            $display("FAIL idle_last%0d: got rdy=%b%b want %b", k, r0_ready, r1_ready, e_rdy);
         end
         advance();
         idle();
         advance();
      end
   endtask

   task automatic test_random();
      logic [VW-1:0] got_v, exp_v;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_din, e_rd0, e_rd1;
      logic e_we;
      int g;
      for (int i = 0; i < 16; i++) begin
         set_in(1, 1, ADDR_W'(i), DATA_W'($urandom), 0, 0, '0, '0);
         advance();
      end
      for (int i = 0; i < 600; i++) begin
         set_in($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
         @(negedge clk);
         g = exp_gnt();
         e_we   = (g == 0) ? r0_we : (g == 1) ? r1_we : 1'b0;
         e_addr = (g == 0) ? r0_addr : (g == 1) ? r1_addr : '0;
         e_din  = (g == 0) ? r0_wdata : (g == 1) ? r1_wdata : '0;
         e_rd0  = (m_pend && m_owner == 0) ? m_pdata : m_held[0];
         e_rd1  = (m_pend && m_owner == 1) ? m_pdata : m_held[1];
         exp_v = {g == 0, g == 1, g >= 0, e_we, e_addr, e_din,
                  m_pend && m_owner == 0, m_pend && m_owner == 1, e_rd0, e_rd1};
         got_v = {r0_ready, r1_ready, ram_en, ram_we, ram_addr, ram_din,
                  r0_rvalid, r1_rvalid, r0_rdata, r1_rdata};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL random%0d: got %h want %h", i, got_v, exp_v);
         end
         advance();
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) exp_mem[i] = '0;
      model_reset();
      test_reset();
      test_write_read();
      test_contention();
      test_single();
      test_war();
      test_reset_mid();
      test_idle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sp_ram_arb.md
Name: sp_ram_arb

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous RAM (1 read-latency; a write does not update read data).
- Each requester issues read/write commands over a valid/ready handshake.
- The arbiter drives the RAM enable, write enable, address and data for the granted requester.
- Read data returns to the issuing requester one cycle later, tagged by a response valid, and is held until that requester's next read completes.

Parameters:
DATA_W, 8, data width, must match the RAM.
ADDR_W, 14, address width, must match the RAM.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
r0_valid  input  1  requester 0 command valid
r0_ready  output  1  requester 0 command accepted this cycle (combinational)
r0_we  input  1  requester 0: 1=write, 0=read
r0_addr  input  ADDR_W  requester 0 address
r0_wdata  input  DATA_W  requester 0 write data
r0_rvalid  output  1  requester 0 read data valid (1-cycle pulse)
r0_rdata  output  DATA_W  requester 0 read data (held)
r1_valid, r1_ready, r1_we, r1_addr, r1_wdata, r1_rvalid, r1_rdata  same as r0_* for requester 1
ram_en  output  1  RAM enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_din  output  DATA_W  RAM write data
ram_dout  input  DATA_W  RAM registered read data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - last_grant=1, so requester 0 wins first.
  - rd_pend=0, rd_owner=0.
  - r0_rvalid=r1_rvalid=0; r0_rdata=r1_rdata=0.
  - r0_ready=r1_ready=0 while rst_n=0.
- Grant, combinational in the same cycle:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
  - rN_ready=1 only for the granted requester; at most one ready is high per cycle.
- RAM drive:
  - ram_en = any grant.
  - ram_we, ram_addr, ram_din are muxed from the granted requester.
  - With no grant: ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
- A command is accepted on a rising edge where rN_valid & rN_ready; last_grant takes the granted index.
- Read response:
  - An accepted read sets rd_pend=1 and rd_owner=granted index for the next cycle; otherwise rd_pend=0.
  - In the cycle with rd_pend=1: r{rd_owner}_rvalid=1 (registered from rd_pend/rd_owner, not from ram_dout).
  - On the edge ending that cycle, ram_dout is captured into r{rd_owner}_rdata.
  - rN_rdata reflects ram_dout combinationally during the rvalid cycle and the held register afterwards.
  - The held value is stable until that requester's next rvalid.
- Latency: read accepted at edge k -> rvalid high during cycle k+1 -> data held from edge k+1.
- Throughput: one command per cycle. No back-pressure on responses; requesters must accept rvalid unconditionally.
- Writes produce no response. A write in the cycle after a read does not disturb that read's response: the RAM output register is unchanged by writes.
- Read-after-write to the same address on consecutive cycles returns the new data.
- Alternation: back-to-back contention alternates grants 0,1,0,1…; a single active requester is granted every cycle.
- Valid deasserted before ready: no command; last_grant unchanged.
- Reset mid-read: a pending rvalid is suppressed and the held rdata is cleared to 0.
- The RAM contents are not cleared by reset.

Test Plan:
1. Reset release, r0 writes 0xA5 to addr 3, then reads addr 3 -> r0_ready=1 both cycles; r0_rvalid pulses one cycle after read acceptance; r0_rdata=0xA5 and stays 0xA5 for 5 more idle cycles.
2. r0 and r1 both hold valid reads (addr 1, addr 2, preloaded 0x11/0x22) for 4 cycles -> grants r0,r1,r0,r1; rvalid pulses alternate; r0_rdata=0x11, r1_rdata=0x22; never both ready.
3. Only r1 valid for 3 cycles with writes 0x01,0x02,0x03 to addr 7, then a read -> r1_ready=1 every cycle; read returns 0x03; r0_rvalid never asserts.
4. r0 reads addr 4 (0x44), next cycle r1 writes 0x99 to addr 4 -> r0_rvalid with 0x44; a subsequent r0 read of addr 4 returns 0x99; r1_rvalid stays 0.
5. rst_n pulsed low asynchronously (mid-cycle) while rd_pend=1 -> rvalid outputs 0 immediately, r0_rdata=r1_rdata=0; after release, with both requesters valid, r0 is granted first.
6. Idle cycles (no valid) -> ram_en=0, ram_we=0, both ready=0; last_grant unchanged, verified by the next contention cycle granting the expected requester.
